// File: rtl/sdrd_sector_arb_if.sv
// Request/engine bus for the SD sector-read arbiter. Signal suffixes are
// given from the arbiter's point of view (slave modport).
interface sdrd_sector_arb_if;
    logic        sdhc_i;
    logic        spi_init_i;
    logic        spi_busy_i;
    logic        spi_start_o;
    logic [31:0] spi_adr_o;
    logic [1:0]  spi_dtype_o;
    logic        fat_req_i;
    logic [31:0] fat_adr_i;
    logic [1:0]  fat_type_i;
    logic        fat_ack_o;
    logic        fat_done_o;
    logic        pic_req_i;
    logic [31:0] pic_adr_i;
    logic        pic_ack_o;
    logic        pic_done_o;
    logic [1:0]  gnt_o;
    logic        err_o;
    logic        err_clr_i;

    modport master (
        output sdhc_i, spi_init_i, spi_busy_i,
        output fat_req_i, fat_adr_i, fat_type_i,
        output pic_req_i, pic_adr_i, err_clr_i,
        input  spi_start_o, spi_adr_o, spi_dtype_o,
        input  fat_ack_o, fat_done_o, pic_ack_o, pic_done_o,
        input  gnt_o, err_o
    );

    modport slave (
        input  sdhc_i, spi_init_i, spi_busy_i,
        input  fat_req_i, fat_adr_i, fat_type_i,
        input  pic_req_i, pic_adr_i, err_clr_i,
        output spi_start_o, spi_adr_o, spi_dtype_o,
        output fat_ack_o, fat_done_o, pic_ack_o, pic_done_o,
        output gnt_o, err_o
    );
endinterface

// File: rtl/sdrd_sector_arb.sv
// Two-requester arbiter/sequencer for the single SPI sector-read engine:
// alternating-priority grant, sector-to-card address mapping, BUSY tracking with timeout.
module sdrd_sector_arb #(
    parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
    input logic         clk,
    input logic         rst,
    sdrd_sector_arb_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, START, WAIT_BUSY, READ, DONE, FAIL
    } state_t;

    state_t      state_q;
    logic [23:0] cnt_q;
    logic        last_pic_q;
    logic        spi_start_q;
    logic [31:0] spi_adr_q;
    logic [1:0]  spi_dtype_q;
    logic        fat_ack_q, fat_done_q, pic_ack_q, pic_done_q;
    logic [1:0]  gnt_q;
    logic        err_q;
    logic        pick_fat;

    // SDSC cards are byte-addressed: sector * 512, upper sector bits dropped.
    function automatic logic [31:0] card_adr(input logic sdhc, input logic [31:0] sector);
        return sdhc ? sector : {sector[22:0], 9'b0};
    endfunction

    always_comb begin
        pick_fat = bus.fat_req_i && (!bus.pic_req_i || last_pic_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_pic_q  <= 1'b1;
            spi_start_q <= 1'b0;
            spi_adr_q   <= '0;
            spi_dtype_q <= '0;
            fat_ack_q   <= 1'b0;
            fat_done_q  <= 1'b0;
            pic_ack_q   <= 1'b0;
            pic_done_q  <= 1'b0;
            gnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            spi_start_q <= 1'b0;
            fat_ack_q   <= 1'b0;
            fat_done_q  <= 1'b0;
            pic_ack_q   <= 1'b0;
            pic_done_q  <= 1'b0;
            if (bus.err_clr_i) err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.spi_init_i && (bus.fat_req_i || bus.pic_req_i)) begin
                        state_q <= START;
                        if (pick_fat) begin
                            fat_ack_q   <= 1'b1;
                            gnt_q       <= 2'b01;
                            spi_adr_q   <= card_adr(bus.sdhc_i, bus.fat_adr_i);
                            spi_dtype_q <= bus.fat_type_i;
                        end else begin
                            pic_ack_q   <= 1'b1;
                            gnt_q       <= 2'b10;
                            spi_adr_q   <= card_adr(bus.sdhc_i, bus.pic_adr_i);
                            spi_dtype_q <= 2'b11;
                        end
                    end
                end
                START, WAIT_BUSY, READ: begin
                    // DONE pulse and ERR are registered on entry so both are visible together.
                    if (!bus.spi_init_i ||
                        (state_q != START && cnt_q == TIMEOUT - 24'd1)) begin
                        state_q    <= FAIL;
                        err_q      <= 1'b1;
                        fat_done_q <= gnt_q[0];
                        pic_done_q <= gnt_q[1];
                    end else if (state_q == START) begin
                        spi_start_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= WAIT_BUSY;
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                        if (state_q == WAIT_BUSY && bus.spi_busy_i) begin
                            state_q <= READ;
                        end else if (state_q == READ && !bus.spi_busy_i) begin
                            state_q    <= DONE;
                            fat_done_q <= gnt_q[0];
                            pic_done_q <= gnt_q[1];
                        end
                    end
                end
                DONE, FAIL: begin
                    last_pic_q <= gnt_q[1];
                    gnt_q      <= '0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.spi_start_o = spi_start_q;
    assign bus.spi_adr_o   = spi_adr_q;
    assign bus.spi_dtype_o = spi_dtype_q;
    assign bus.fat_ack_o   = fat_ack_q;
    assign bus.fat_done_o  = fat_done_q;
    assign bus.pic_ack_o   = pic_ack_q;
    assign bus.pic_done_o  = pic_done_q;
    assign bus.gnt_o       = gnt_q;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_sdrd_sector_arb.sv
// Directed bench for sdrd_sector_arb with TIMEOUT=16; each task checks one scenario.
module tb_sdrd_sector_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   n_fat_ack = 0, n_pic_ack = 0, n_fat_done = 0, n_pic_done = 0;

    sdrd_sector_arb_if bus ();

    sdrd_sector_arb #(.TIMEOUT(24'd16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.fat_ack_o)  n_fat_ack++;
        if (bus.pic_ack_o)  n_pic_ack++;
        if (bus.fat_done_o) n_fat_done++;
        if (bus.pic_done_o) n_pic_done++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.sdhc_i = 1'b1; bus.spi_init_i = 1'b1; bus.spi_busy_i = 1'b0;
        bus.fat_req_i = 1'b0; bus.fat_adr_i = '0; bus.fat_type_i = '0;
        bus.pic_req_i = 1'b0; bus.pic_adr_i = '0; bus.err_clr_i = 1'b0;
        step(); step();
        total++; if (bus.spi_start_o !== 1'b0) begin bad++; $display("FAIL rst_start: got %b want 0", bus.spi_start_o); end
        total++; if (bus.spi_adr_o !== 32'h0) begin bad++; $display("FAIL rst_adr: got %h want 0", bus.spi_adr_o); end
        total++; if (bus.spi_dtype_o !== 2'b00) begin bad++; $display("FAIL rst_dtype: got %b want 00", bus.spi_dtype_o); end
        total++; if ({bus.fat_ack_o, bus.fat_done_o, bus.pic_ack_o, bus.pic_done_o} !== 4'b0) begin
            bad++; $display("FAIL rst_ackdone: got %b want 0000", {bus.fat_ack_o, bus.fat_done_o, bus.pic_ack_o, bus.pic_done_o}); end
        total++; if (bus.gnt_o !== 2'b00) begin bad++; $display("FAIL rst_gnt: got %b want 00", bus.gnt_o); end
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.err_o); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_fat_read();
        bus.sdhc_i = 1'b1; bus.fat_adr_i = 32'h0000_2000; bus.fat_type_i = 2'b01; bus.fat_req_i = 1'b1;
        step();
        total++; if (bus.fat_ack_o !== 1'b1 || bus.pic_ack_o !== 1'b0) begin
            bad++; $display("FAIL fat_ack: got fat=%b pic=%b want fat=1 pic=0", bus.fat_ack_o, bus.pic_ack_o); end
        total++; if (bus.gnt_o !== 2'b01) begin bad++; $display("FAIL fat_gnt: got %b want 01", bus.gnt_o); end
        total++; if (bus.spi_start_o !== 1'b0) begin bad++; $display("FAIL fat_start_early: got %b want 0", bus.spi_start_o); end
        total++; if (bus.spi_adr_o !== 32'h0000_2000) begin bad++; $display("FAIL fat_adr: got %h want 00002000", bus.spi_adr_o); end
        total++; if (bus.spi_dtype_o !== 2'b01) begin bad++; $display("FAIL fat_dtype: got %b want 01", bus.spi_dtype_o); end
        bus.fat_req_i = 1'b0; bus.fat_adr_i = 32'hDEAD_BEEF; bus.fat_type_i = 2'b10;
        step();
        total++; if (bus.spi_start_o !== 1'b1) begin bad++; $display("FAIL fat_start: got %b want 1", bus.spi_start_o); end
        total++; if (bus.fat_ack_o !== 1'b0) begin bad++; $display("FAIL fat_ack_len: got %b want 0", bus.fat_ack_o); end
        step();
        total++; if (bus.spi_start_o !== 1'b0) begin bad++; $display("FAIL fat_start_len: got %b want 0", bus.spi_start_o); end
        bus.spi_busy_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if (bus.fat_done_o !== 1'b0 || bus.gnt_o !== 2'b01 || bus.spi_adr_o !== 32'h0000_2000) begin
                bad++; $display("FAIL fat_busy_hold: got done=%b gnt=%b adr=%h want 0 01 00002000", bus.fat_done_o, bus.gnt_o, bus.spi_adr_o); end
        end
        bus.spi_busy_i = 1'b0;
        step();
        total++; if (bus.fat_done_o !== 1'b1 || bus.pic_done_o !== 1'b0) begin
            bad++; $display("FAIL fat_done: got fat=%b pic=%b want fat=1 pic=0", bus.fat_done_o, bus.pic_done_o); end
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL fat_err: got %b want 0", bus.err_o); end
        total++; if (bus.gnt_o !== 2'b01 || bus.spi_dtype_o !== 2'b01) begin
            bad++; $display("FAIL fat_done_gnt: got gnt=%b dtype=%b want 01 01", bus.gnt_o, bus.spi_dtype_o); end
        step();
        total++; if (bus.fat_done_o !== 1'b0 || bus.gnt_o !== 2'b00) begin
            bad++; $display("FAIL fat_release: got done=%b gnt=%b want 0 00", bus.fat_done_o, bus.gnt_o); end
    endtask

    task automatic test_sdsc();
        bus.sdhc_i = 1'b0; bus.pic_adr_i = 32'hFF80_0011; bus.pic_req_i = 1'b1;
        step();
        total++; if (bus.pic_ack_o !== 1'b1 || bus.fat_ack_o !== 1'b0) begin
            bad++; $display("FAIL sdsc_ack: got pic=%b fat=%b want pic=1 fat=0", bus.pic_ack_o, bus.fat_ack_o); end
        total++; if (bus.gnt_o !== 2'b10) begin bad++; $display("FAIL sdsc_gnt: got %b want 10", bus.gnt_o); end
        total++; if (bus.spi_adr_o !== 32'h0000_2200) begin bad++; $display("FAIL sdsc_adr: got %h want 00002200", bus.spi_adr_o); end
        total++; if (bus.spi_dtype_o !== 2'b11) begin bad++; $display("FAIL sdsc_dtype: got %b want 11", bus.spi_dtype_o); end
        bus.pic_req_i = 1'b0;
        step();
        total++; if (bus.spi_start_o !== 1'b1) begin bad++; $display("FAIL sdsc_start: got %b want 1", bus.spi_start_o); end
        bus.spi_busy_i = 1'b1;
        step();
        bus.spi_busy_i = 1'b0;
        step();
        total++; if (bus.pic_done_o !== 1'b1 || bus.fat_done_o !== 1'b0) begin
            bad++; $display("FAIL sdsc_done: got pic=%b fat=%b want pic=1 fat=0", bus.pic_done_o, bus.fat_done_o); end
        step();
        total++; if (bus.pic_done_o !== 1'b0 || bus.gnt_o !== 2'b00) begin
            bad++; $display("FAIL sdsc_release: got done=%b gnt=%b want 0 00", bus.pic_done_o, bus.gnt_o); end
    endtask

    task automatic test_contention();
        int b_fa, b_pa, b_fd, b_pd;
        logic [1:0] expg;
        bit ok;
        bus.sdhc_i = 1'b1; bus.fat_adr_i = 32'h100; bus.fat_type_i = 2'b10; bus.pic_adr_i = 32'h200;
        b_fa = n_fat_ack; b_pa = n_pic_ack; b_fd = n_fat_done; b_pd = n_pic_done;
        bus.fat_req_i = 1'b1; bus.pic_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expg = (i % 2 == 0) ? 2'b01 : 2'b10;
            ok = 1'b0;
            for (int w = 0; w < 8 && !ok; w++) begin
                step();
                if (bus.fat_ack_o || bus.pic_ack_o) ok = 1'b1;
            end
            total++; if (!ok) begin bad++; $display("FAIL cont_ack_wait[%0d]: got no ack want ack within 8 cycles", i); end
            total++; if ({bus.pic_ack_o, bus.fat_ack_o} !== expg || bus.gnt_o !== expg) begin
                bad++; $display("FAIL cont_order[%0d]: got ack=%b gnt=%b want %b", i, {bus.pic_ack_o, bus.fat_ack_o}, bus.gnt_o, expg); end
            step(); step();
            bus.spi_busy_i = 1'b1;
            step();
            bus.spi_busy_i = 1'b0;
            ok = 1'b0;
            for (int w = 0; w < 8 && !ok; w++) begin
                step();
                if (bus.fat_done_o || bus.pic_done_o) ok = 1'b1;
            end
            if (i == 3) begin bus.fat_req_i = 1'b0; bus.pic_req_i = 1'b0; end
            total++; if (!ok || {bus.pic_done_o, bus.fat_done_o} !== expg) begin
                bad++; $display("FAIL cont_done[%0d]: got %b want %b", i, {bus.pic_done_o, bus.fat_done_o}, expg); end
        end
        step();
        total++; if (n_fat_ack - b_fa != 2 || n_pic_ack - b_pa != 2) begin
            bad++; $display("FAIL cont_ack_count: got fat=%0d pic=%0d want 2 2", n_fat_ack - b_fa, n_pic_ack - b_pa); end
        total++; if (n_fat_done - b_fd != 2 || n_pic_done - b_pd != 2) begin
            bad++; $display("FAIL cont_done_count: got fat=%0d pic=%0d want 2 2", n_fat_done - b_fd, n_pic_done - b_pd); end
    endtask

    task automatic test_timeout();
        bit early;
        bus.sdhc_i = 1'b1; bus.fat_adr_i = 32'h55; bus.fat_type_i = 2'b00; bus.fat_req_i = 1'b1;
        step();
        total++; if (bus.fat_ack_o !== 1'b1) begin bad++; $display("FAIL to_ack: got %b want 1", bus.fat_ack_o); end
        bus.fat_req_i = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.fat_done_o !== 1'b0) early = 1'b1;
        end
        total++; if (early) begin bad++; $display("FAIL to_early: got done before 16 cycles want none"); end
        step();
        total++; if (bus.fat_done_o !== 1'b1 || bus.err_o !== 1'b1) begin
            bad++; $display("FAIL to_fail: got done=%b err=%b want 1 1", bus.fat_done_o, bus.err_o); end
        step();
        total++; if (bus.fat_done_o !== 1'b0 || bus.gnt_o !== 2'b00) begin
            bad++; $display("FAIL to_release: got done=%b gnt=%b want 0 00", bus.fat_done_o, bus.gnt_o); end
        step(); step(); step();
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL to_err_hold: got %b want 1", bus.err_o); end
        bus.err_clr_i = 1'b1;
        step();
        bus.err_clr_i = 1'b0;
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL to_err_clr: got %b want 0", bus.err_o); end
    endtask

    task automatic test_init_drop();
        bit seen;
        bus.fat_adr_i = 32'h77; bus.fat_req_i = 1'b1;
        step();
        bus.fat_req_i = 1'b0;
        step();
        bus.spi_busy_i = 1'b1;
        step();
        bus.spi_init_i = 1'b0;
        step();
        total++; if (bus.fat_done_o !== 1'b1 || bus.err_o !== 1'b1) begin
            bad++; $display("FAIL init_fail: got done=%b err=%b want 1 1", bus.fat_done_o, bus.err_o); end
        bus.spi_busy_i = 1'b0; bus.fat_req_i = 1'b1;
        step();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus.fat_ack_o !== 1'b0 || bus.gnt_o !== 2'b00) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL init_no_grant: got ack/gnt with SPI_INIT=0 want none"); end
        bus.fat_req_i = 1'b0; bus.spi_init_i = 1'b1; bus.err_clr_i = 1'b1;
        step();
        bus.err_clr_i = 1'b0;
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL init_err_clr: got %b want 0", bus.err_o); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bus.sdhc_i = 1'b1; bus.pic_adr_i = 32'h300; bus.pic_req_i = 1'b1;
        step();
        bus.pic_req_i = 1'b0;
        step();
        bus.spi_busy_i = 1'b1;
        step(); step();
        #2 rst = 1'b1;
        #1;
        total++; if (bus.gnt_o !== 2'b00 || bus.spi_start_o !== 1'b0) begin
            bad++; $display("FAIL rmid_outs: got gnt=%b start=%b want 00 0", bus.gnt_o, bus.spi_start_o); end
        total++; if (bus.spi_adr_o !== 32'h0 || bus.spi_dtype_o !== 2'b00 || bus.pic_done_o !== 1'b0) begin
            bad++; $display("FAIL rmid_bus: got adr=%h dtype=%b done=%b want 0 00 0", bus.spi_adr_o, bus.spi_dtype_o, bus.pic_done_o); end
        bus.spi_busy_i = 1'b0; bus.pic_req_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b0;
        for (int w = 0; w < 6 && !ok; w++) begin
            step();
            if (bus.pic_ack_o) ok = 1'b1;
        end
        total++; if (!ok || bus.gnt_o !== 2'b10 || bus.spi_adr_o !== 32'h300) begin
            bad++; $display("FAIL rmid_regrant: got ack=%b gnt=%b adr=%h want 1 10 00000300", bus.pic_ack_o, bus.gnt_o, bus.spi_adr_o); end
        bus.pic_req_i = 1'b0;
        step();
        total++; if (bus.spi_start_o !== 1'b1) begin bad++; $display("FAIL rmid_start: got %b want 1", bus.spi_start_o); end
        bus.spi_busy_i = 1'b1;
        step();
        bus.spi_busy_i = 1'b0;
        step();
        total++; if (bus.pic_done_o !== 1'b1 || bus.err_o !== 1'b0) begin
            bad++; $display("FAIL rmid_done: got done=%b err=%b want 1 0", bus.pic_done_o, bus.err_o); end
        step();
    endtask

    initial begin
        test_reset();
        test_fat_read();
        test_sdsc();
        test_contention();
        test_timeout();
        test_init_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
